// File: rtl/spi_syn_master.sv
// spi_syn_master: oversampled SPI mode-0 master (CPOL=0, CPHA=0), MSB first,
// 8-bit frames. Every sclk phase and the cs-high gap last at least CLK_DIV
// system clocks, so a slave that triple-synchronises sclk/cs/mosi keeps up.
//
// Optional feature macro: SPI_SYN_MASTER_BURST_EN
//   Adds input tx_burst and a HOLD state that keeps cs low between bytes.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   tx_data   byte to send, captured when tx_start is accepted
//   tx_start  frame request, accepted only while idle and not on a done cycle
//   tx_burst  (burst build only) keep cs low after this byte
//   busy      high from acceptance until the frame completes
//   rx_data   byte received on miso, updated together with done
//   done      one-clock pulse at frame completion
//   sclk      SPI clock, idles low
//   cs        active-low chip select, idles high
//   mosi      serial data out
//   miso      serial data in, sampled at the end of each sclk-high phase
module spi_syn_master #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
`ifdef SPI_SYN_MASTER_BURST_EN
    input  logic       tx_burst,
`endif
    output logic       busy,
    output logic [7:0] rx_data,
    output logic       done,
    output logic       sclk,
    output logic       cs,
    output logic       mosi,
    input  logic       miso
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] PH_LAST = CNT_W'(CLK_DIV - 1);

    // Reject divider values the slave synchroniser cannot follow.
    generate
        if (CLK_DIV < 4 || CLK_DIV > 255) begin : g_bad_clk_div
            $error("spi_syn_master: CLK_DIV must be in 4..255");
        end
    endgenerate

`ifdef SPI_SYN_MASTER_BURST_EN
    typedef enum logic [2:0] {IDLE, LEAD, SCK_LO, SCK_HI, TRAIL, GAP, HOLD} state_t;
`else
    typedef enum logic [2:0] {IDLE, LEAD, SCK_LO, SCK_HI, TRAIL, GAP} state_t;
`endif

    state_t           r_state;
    logic [CNT_W-1:0] r_phase;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_tx_shift;
    logic [7:0]       r_rx_shift;
`ifdef SPI_SYN_MASTER_BURST_EN
    logic             r_burst;
`endif

    logic             w_ph_last;
    logic [7:0]       w_rx_next;

    assign w_ph_last = (r_phase == PH_LAST);
    assign w_rx_next = {r_rx_shift[6:0], miso};

    // Frame sequencer; all outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_phase    <= '0;
            r_bit_cnt  <= 3'd0;
            r_tx_shift <= 8'd0;
            r_rx_shift <= 8'd0;
`ifdef SPI_SYN_MASTER_BURST_EN
            r_burst    <= 1'b0;
`endif
            busy       <= 1'b0;
            rx_data    <= 8'd0;
            done       <= 1'b0;
            sclk       <= 1'b0;
            cs         <= 1'b1;
            mosi       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_phase <= '0;
                    if (busy) begin
                        // Byte captured last cycle: open the frame.
                        cs      <= 1'b0;
                        mosi    <= r_tx_shift[7];
                        r_state <= LEAD;
                    end else if (tx_start && !done) begin
                        r_tx_shift <= tx_data;
                        busy       <= 1'b1;
`ifdef SPI_SYN_MASTER_BURST_EN
                        r_burst    <= tx_burst;
`endif
                    end
                end
                LEAD: begin
                    // Setup spans a full sclk period: two CLK_DIV passes,
                    // the bit counter (idle at 0 here) marks the second.
                    if (w_ph_last) begin
                        r_phase <= '0;
                        if (r_bit_cnt == 3'd0) begin
                            r_bit_cnt <= 3'd1;
                        end else begin
                            r_bit_cnt <= 3'd0;
                            sclk      <= 1'b1;
                            r_state   <= SCK_HI;
                        end
                    end else begin
                        r_phase <= r_phase + CNT_W'(1);
                    end
                end
                SCK_LO: begin
                    if (w_ph_last) begin
                        r_phase <= '0;
                        sclk    <= 1'b1;
                        r_state <= SCK_HI;
                    end else begin
                        r_phase <= r_phase + CNT_W'(1);
                    end
                end
                SCK_HI: begin
                    if (w_ph_last) begin
                        r_phase    <= '0;
                        sclk       <= 1'b0;
                        r_rx_shift <= w_rx_next;
                        if (r_bit_cnt == 3'd7) begin
                            r_bit_cnt <= 3'd0;
`ifdef SPI_SYN_MASTER_BURST_EN
                            if (r_burst) begin
                                done    <= 1'b1;
                                busy    <= 1'b0;
                                rx_data <= w_rx_next;
                                r_state <= HOLD;
                            end else begin
                                r_state <= TRAIL;
                            end
`else
                            r_state <= TRAIL;
`endif
                        end else begin
                            r_bit_cnt  <= r_bit_cnt + 3'd1;
                            r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                            mosi       <= r_tx_shift[6];
                            r_state    <= SCK_LO;
                        end
                    end else begin
                        r_phase <= r_phase + CNT_W'(1);
                    end
                end
                TRAIL: begin
                    if (w_ph_last) begin
                        r_phase <= '0;
                        cs      <= 1'b1;
                        r_state <= GAP;
                    end else begin
                        r_phase <= r_phase + CNT_W'(1);
                    end
                end
                GAP: begin
                    if (w_ph_last) begin
                        r_phase <= '0;
                        done    <= 1'b1;
                        rx_data <= r_rx_shift;
                        busy    <= 1'b0;
                        mosi    <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_phase <= r_phase + CNT_W'(1);
                    end
                end
`ifdef SPI_SYN_MASTER_BURST_EN
                HOLD: begin
                    // cs stays low; the next byte skips LEAD.
                    r_phase <= '0;
                    if (tx_start && !done) begin
                        r_tx_shift <= tx_data;
                        r_burst    <= tx_burst;
                        mosi       <= tx_data[7];
                        busy       <= 1'b1;
                        r_bit_cnt  <= 3'd0;
                        r_state    <= SCK_LO;
                    end
                end
`endif
                default: begin
                    r_phase <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_syn_master.sv
// Scoreboard bench for spi_syn_master with a behavioural mode-0 slave
// (miso driver + mosi receiver) attached to the SPI pins.
`timescale 1ns/1ps
module tb_spi_syn_master;

    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned LAT     = 1 + 19 * CLK_DIV;   // accept edge to done edge
    localparam int unsigned PERIOD  = LAT + 2;            // held tx_start: done cycle is skipped

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'd0;
    logic       tx_start = 1'b0;
`ifdef SPI_SYN_MASTER_BURST_EN
    logic       tx_burst = 1'b0;
`endif
    logic       busy, done, sclk, cs, mosi;
    logic [7:0] rx_data;
    logic       miso = 1'b0;

    spi_syn_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_data  (tx_data),
        .tx_start (tx_start),
`ifdef SPI_SYN_MASTER_BURST_EN
        .tx_burst (tx_burst),
`endif
        .busy     (busy),
        .rx_data  (rx_data),
        .done     (done),
        .sclk     (sclk),
        .cs       (cs),
        .mosi     (mosi),
        .miso     (miso)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  rx;
        int unsigned cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  exp_tx_q[$];
    logic [7:0]  miso_q[$];

    int unsigned cyc = 0;
    int          errors = 0;
    int          checks = 0;
    int          exp_rises = 8;

    // Monitor / slave model state
    logic       p_cs = 1'b1, p_sclk = 1'b0, p_done = 1'b0;
    int         gap = 0, hi_len = 0, rises = 0, s_bits = 0, m_cnt = 0;
    logic [7:0] s_shift = 8'd0, m_shift = 8'd0, pre = 8'd0;
    logic       pre_v = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor and slave model, sampled away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            p_cs = 1'b1; p_sclk = 1'b0; p_done = 1'b0;
            gap = 0; hi_len = 0; rises = 0; s_bits = 0; m_cnt = 0;
            s_shift = 8'd0; m_shift = 8'd0; pre_v = 1'b0; miso = 1'b0;
        end else begin
            if (cs) gap++;
            if (p_cs && !cs) begin
                check("cs_high_gap_ge_div", 32'(gap >= int'(CLK_DIV)), 32'd1);
                if (pre_v) m_shift = pre;
                else if (miso_q.size() > 0) m_shift = miso_q.pop_front();
                else m_shift = 8'd0;
                pre_v = 1'b0; m_cnt = 0; s_bits = 0; rises = 0;
                miso = m_shift[7];
            end
            if (!cs) gap = 0;
            if (!p_cs && cs) begin
                check("sclk_rises_per_cs", 32'(rises), 32'(exp_rises));
                check("whole_bytes_at_cs_rise", 32'(s_bits), 32'd0);
            end
            if (!p_sclk && sclk) begin
                check("sclk_rise_with_cs_low", 32'(cs), 32'd0);
                rises++; hi_len = 1; pre_v = 1'b0;
                s_shift = {s_shift[6:0], mosi};
                s_bits++;
                if (s_bits == 8) begin
                    s_bits = 0;
                    if (exp_tx_q.size() > 0) check("slave_rx_byte", 32'(s_shift), 32'(exp_tx_q.pop_front()));
                    else check("unexpected_slave_byte", 32'(s_shift), 32'hFFFF_FFFF);
                end
            end else if (p_sclk && sclk) begin
                hi_len++;
            end
            if (p_sclk && !sclk) begin
                check("sclk_high_len", 32'(hi_len), 32'(CLK_DIV));
                m_cnt++;
                if (m_cnt == 8) begin
                    m_cnt = 0;
                    // Preload the next byte: used directly in a burst or at the next cs fall.
                    if (miso_q.size() > 0) begin
                        pre = miso_q.pop_front(); pre_v = 1'b1; m_shift = pre;
                    end else begin
                        m_shift = 8'd0;
                    end
                end else begin
                    m_shift = {m_shift[6:0], 1'b0};
                end
                miso = m_shift[7];
            end
            if (done) begin
                check("done_one_cycle", 32'(p_done), 32'd0);
                if (exp_q.size() > 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rx_data", 32'(rx_data), 32'(e.rx));
                    check("done_cycle", cyc, e.cyc);
                end else begin
                    check("unexpected_done", 32'(rx_data), 32'hFFFF_FFFF);
                end
            end
            p_cs = cs; p_sclk = sclk; p_done = done;
        end
    end

    task automatic send(input logic [7:0] tx, input logic [7:0] mi, input int unsigned lat);
        exp_t e;
        @(negedge clk);
        tx_data  = tx;
        tx_start = 1'b1;
        e.rx  = mi;
        e.cyc = cyc + 1 + lat;
        exp_q.push_back(e);
        exp_tx_q.push_back(tx);
        miso_q.push_back(mi);
        @(negedge clk);
        tx_start = 1'b0;
        tx_data  = ~tx;   // later changes must not affect the frame
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp_tx_q.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) check("wait_timeout", 32'd1, 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_cs"},      32'(cs),      32'd1);
        check({tag, "_sclk"},    32'(sclk),    32'd0);
        check({tag, "_mosi"},    32'(mosi),    32'd0);
        check({tag, "_busy"},    32'(busy),    32'd0);
        check({tag, "_done"},    32'(done),    32'd0);
        check({tag, "_rx_data"}, 32'(rx_data), 32'd0);
    endtask

    initial begin
        int unsigned e0;
        logic [7:0] held_mi [3];
        exp_t e;
        held_mi[0] = 8'h96; held_mi[1] = 8'h3F; held_mi[2] = 8'hE7;

        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        // Single frame, latency and bit order
        send(8'hA5, 8'h3C, LAT);
        wait_idle();

        // tx_start and tx_data changes during a busy frame are ignored
        send(8'h66, 8'h99, LAT);
        repeat (20) @(negedge clk);
        tx_data = 8'h99; tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        wait_idle();

        // Back-to-back loopback bytes
        send(8'h00, 8'h81, LAT); wait_idle();
        send(8'hFF, 8'h00, LAT); wait_idle();
        send(8'h81, 8'hFF, LAT); wait_idle();

        // tx_start held for 200 cycles: accepts at +0, +79, +158
        @(negedge clk);
        e0 = cyc + 1;
        tx_data = 8'h5A; tx_start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            e.rx  = held_mi[i];
            e.cyc = e0 + 32'(i) * PERIOD + LAT;
            exp_q.push_back(e);
            exp_tx_q.push_back(8'h5A);
            miso_q.push_back(held_mi[i]);
        end
        repeat (200) @(negedge clk);
        tx_start = 1'b0;
        wait_idle();

        // Reset mid-frame after the third sclk rise
        send(8'h77, 8'h55, LAT);
        begin
            int n;
            n = 0;
            while (n < 500) begin
                @(negedge clk);
                #1;
                if (rises >= 3) break;
                n++;
            end
            if (n >= 500) check("wait_third_rise_timeout", 32'd1, 32'd0);
        end
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midreset");
        exp_q.delete(); exp_tx_q.delete(); miso_q.delete();
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        send(8'hC3, 8'h96, LAT);
        wait_idle();

`ifdef SPI_SYN_MASTER_BURST_EN
        // Two bytes under one cs: 0x11 with burst, 0x22 closes the frame
        exp_rises = 16;
        miso_q.push_back(8'hE1); miso_q.push_back(8'h4B);
        exp_tx_q.push_back(8'h11); exp_tx_q.push_back(8'h22);
        @(negedge clk);
        e.rx = 8'hE1; e.cyc = cyc + 1 + 1 + 17 * CLK_DIV;
        exp_q.push_back(e);
        tx_data = 8'h11; tx_burst = 1'b1; tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0; tx_burst = 1'b0; tx_data = 8'h00;
        begin
            int n;
            n = 0;
            while (exp_q.size() != 0 && n < 1000) begin
                @(negedge clk);
                n++;
            end
            if (n >= 1000) check("burst_first_timeout", 32'd1, 32'd0);
        end
        @(negedge clk);
        check("hold_cs_low", 32'(cs), 32'd0);
        check("hold_busy_low", 32'(busy), 32'd0);
        e.rx = 8'h4B; e.cyc = cyc + 1 + 18 * CLK_DIV;
        exp_q.push_back(e);
        tx_data = 8'h22; tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0; tx_data = 8'hFF;
        wait_idle();
        exp_rises = 8;
`endif

        repeat (10) @(negedge clk);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("exp_tx_q_drained", 32'(exp_tx_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #2ms;
        errors++;
        checks++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
